// File: rtl/result_arbiter.sv
// rtl/result_arbiter.sv - round-robin collector of worker pixel results onto one frame-buffer write port
// Grants one finished worker at a time, writes its pixel, then acks it; counts pixels for frame completion.
module result_arbiter #(
    parameter int NUM_WORKERS = 16,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int ITER_BITS   = 8,
    parameter int ADDR_BITS   = 19
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic [NUM_WORKERS-1:0]                jw_done,
    input  logic [NUM_WORKERS-1:0][9:0]           jw_x,
    input  logic [NUM_WORKERS-1:0][9:0]           jw_y,
    input  logic [NUM_WORKERS-1:0][ITER_BITS-1:0] jw_iter,
    output logic [NUM_WORKERS-1:0]                jw_ack,
    output logic                                  wr_req,
    output logic [ADDR_BITS-1:0]                  wr_addr,
    output logic [ITER_BITS-1:0]                  wr_data,
    input  logic                                  wr_ack,
    output logic                                  frame_done,
    output logic                                  oob_err
);

    localparam int IDX_BITS = $clog2(NUM_WORKERS);
    localparam logic [ADDR_BITS-1:0] FRAME_PIX = ADDR_BITS'(SCREEN_W * SCREEN_H);
    localparam logic [ADDR_BITS-1:0] W_ADDR    = ADDR_BITS'(SCREEN_W);
    localparam logic [10:0]          W_LIM     = 11'(SCREEN_W);
    localparam logic [10:0]          H_LIM     = 11'(SCREEN_H);
    localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(NUM_WORKERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [IDX_BITS-1:0]   rr_ptr;
    logic [IDX_BITS-1:0]   grant_idx;
    logic [ADDR_BITS-1:0]  pix_cnt;

    logic                  found;
    logic [IDX_BITS-1:0]   sel_idx;
    logic [IDX_BITS-1:0]   cand;
    logic [9:0]            sel_x;
    logic [9:0]            sel_y;
    logic [ITER_BITS-1:0]  sel_iter;
    logic                  in_range;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic                  oob_set;
    logic                  pix_inc;

    // First requesting channel at or after rr_ptr, wrapping past the last worker.
    always_comb begin
        found   = 1'b0;
        sel_idx = rr_ptr;
        cand    = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            cand = IDX_BITS'((int'(rr_ptr) + i) % NUM_WORKERS);
            if (!found && jw_done[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        sel_x    = jw_x[sel_idx];
        sel_y    = jw_y[sel_idx];
        sel_iter = jw_iter[sel_idx];
        in_range = ({1'b0, sel_x} < W_LIM) && ({1'b0, sel_y} < H_LIM);
        sel_addr = ADDR_BITS'(sel_y) * W_ADDR + ADDR_BITS'(sel_x);
        oob_set  = (state == IDLE) && found && !in_range;
        pix_inc  = (state == WRITE) && wr_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = in_range ? WRITE : ACK;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_req = (state == WRITE);
        jw_ack = '0;
        if (state == ACK) begin
            jw_ack = NUM_WORKERS'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant_idx <= sel_idx;
                wr_addr   <= sel_addr;
                wr_data   <= sel_iter;
            end
            if (state == ACK) begin
                rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // clear overrides any same-cycle increment or out-of-range detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            oob_err    <= 1'b0;
        end else if (clear) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            if (oob_set) begin
                oob_err <= 1'b1;
            end
            if (pix_inc && pix_cnt != FRAME_PIX) begin
                pix_cnt <= pix_cnt + 1'b1;
                if (pix_cnt + 1'b1 == FRAME_PIX) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_arbiter.sv
// tb/tb_result_arbiter.sv - scoreboard bench for result_arbiter with a round-robin order model
// Workers are modelled as per-channel result queues; a 640x3 frame keeps completion reachable.
module tb_result_arbiter;

    localparam int W     = 640;
    localparam int H     = 3;
    localparam int FRAME = W * H;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] iter;
    } item_t;

    typedef struct {
        int idx;
        int addr;
        int data;
        bit oob;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    logic [15:0]           jw_done;
    logic [15:0][9:0]      jw_x;
    logic [15:0][9:0]      jw_y;
    logic [15:0][7:0]      jw_iter;
    logic [15:0]           jw_ack;
    logic                  wr_req;
    logic [18:0]           wr_addr;
    logic [7:0]            wr_data;
    logic                  wr_ack;
    logic                  frame_done;
    logic                  oob_err;

    int    total = 0;
    int    bad   = 0;
    int    model_ptr = 0;
    int    ack_prob = 100;
    int    stall_left = 0;
    int    last_req_len = 0;
    item_t pend[16][$];
    item_t wq[16][$];
    exp_t  exp_q[$];

    result_arbiter #(
        .NUM_WORKERS(16), .SCREEN_W(W), .SCREEN_H(H), .ITER_BITS(8), .ADDR_BITS(19)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .jw_done(jw_done), .jw_x(jw_x), .jw_y(jw_y), .jw_iter(jw_iter),
        .jw_ack(jw_ack), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .frame_done(frame_done), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic add_item(input int w, input int x, input int y, input int it);
        item_t i;
        i.x = 10'(x);
        i.y = 10'(y);
        i.iter = 8'(it);
        pend[w].push_back(i);
    endtask

    // Expected order: repeatedly take the first worker with work at or after the pointer.
    task automatic launch();
        bit    any;
        int    c;
        item_t it;
        exp_t  e;
        do begin
            any = 1'b0;
            for (int i = 0; i < 16; i++) begin
                c = (model_ptr + i) % 16;
                if (!any && pend[c].size() > 0) begin
                    any    = 1'b1;
                    it     = pend[c].pop_front();
                    e.idx  = c;
                    e.addr = int'(it.y) * W + int'(it.x);
                    e.data = int'(it.iter);
                    e.oob  = (int'(it.x) >= W) || (int'(it.y) >= H);
                    exp_q.push_back(e);
                    wq[c].push_back(it);
                    model_ptr = (c + 1) % 16;
                end
            end
        end while (any);
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0);
        for (int i = 0; i < 16; i++) begin
            if (wq[i].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic wait_batch(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (!busy()) return;
        end
        chk("batch_timeout", 32'(exp_q.size()), 0);
        $fatal(1, "FAIL batch_timeout pending=%0d", exp_q.size());
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic full_batch(input int per_worker);
        for (int w = 0; w < 16; w++) begin
            for (int j = 0; j < per_worker; j++) begin
                add_item(w, $urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(255));
            end
        end
        launch();
    endtask

    // Worker and frame-buffer models: present queued results, drop done after ack, stall wr_ack.
    bit gap[16];
    initial begin
        jw_done = '0;
        jw_x    = '0;
        jw_y    = '0;
        jw_iter = '0;
        wr_ack  = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 16; k++) begin
                if (jw_ack[k] === 1'b1) begin
                    if (wq[k].size() > 0) void'(wq[k].pop_front());
                    jw_done[k] = 1'b0;
                    gap[k] = 1'b1;
                end else if (gap[k]) begin
                    gap[k] = 1'b0;
                end else if (!jw_done[k] && wq[k].size() > 0) begin
                    jw_x[k]    = wq[k][0].x;
                    jw_y[k]    = wq[k][0].y;
                    jw_iter[k] = wq[k][0].iter;
                    jw_done[k] = 1'b1;
                end
            end
            if (wr_req === 1'b1 && stall_left > 0) begin
                wr_ack = 1'b0;
                stall_left--;
            end else begin
                wr_ack = ($urandom_range(99) < ack_prob);
            end
        end
    end

    // Monitor: compares every ack and write against the scoreboard, tracks frame/oob flags.
    initial begin
        bit          prev_req, got_write, saw_req, exp_done, exp_oob, hs;
        int          cnt, req_len;
        logic [18:0] lat_addr, w_addr;
        logic [7:0]  lat_data, w_data;
        logic [15:0] oh;
        exp_t        e;
        prev_req = 0; got_write = 0; saw_req = 0; exp_done = 0; exp_oob = 0;
        cnt = 0; req_len = 0; lat_addr = '0; lat_data = '0; w_addr = '0; w_data = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                prev_req = 0; got_write = 0; saw_req = 0; cnt = 0; exp_done = 0; exp_oob = 0;
            end else begin
                chk("frame_done", 32'(frame_done), 32'(exp_done));
                hs = (wr_req === 1'b1) && (wr_ack === 1'b1);
                if (wr_req === 1'b1) begin
                    saw_req = 1;
                    if (prev_req) begin
                        chk("addr_stable", 32'(wr_addr), 32'(lat_addr));
                        chk("data_stable", 32'(wr_data), 32'(lat_data));
                        req_len++;
                    end else begin
                        lat_addr = wr_addr;
                        lat_data = wr_data;
                        req_len  = 1;
                    end
                    if (hs) begin
                        chk("single_write", 32'(got_write), 0);
                        got_write = 1;
                        w_addr = wr_addr;
                        w_data = wr_data;
                        last_req_len = req_len;
                    end
                end
                if (jw_ack !== 16'h0) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_expected", 32'(jw_ack), 0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 16'd1 << e.idx;
                        chk("ack_idx", 32'(jw_ack), 32'(oh));
                        chk("ack_no_req", 32'(wr_req), 0);
                        if (e.oob) begin
                            chk("oob_no_write", 32'(saw_req), 0);
                            chk("oob_err_set", 32'(oob_err), 1);
                            exp_oob = 1;
                        end else begin
                            chk("write_done", 32'(got_write), 1);
                            chk("wr_addr", 32'(w_addr), e.addr);
                            chk("wr_data", 32'(w_data), e.data);
                            chk("oob_err_hold", 32'(oob_err), 32'(exp_oob));
                        end
                    end
                    got_write = 0;
                    saw_req = 0;
                end
                if (clear === 1'b1) begin
                    cnt = 0; exp_done = 0; exp_oob = 0;
                end else if (hs) begin
                    cnt++;
                    if (cnt == FRAME) exp_done = 1;
                end
                prev_req = wr_req;
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        // Reset with every worker requesting; worker 0 returns once more afterwards.
        for (int w = 0; w < 16; w++) add_item(w, $urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(255));
        add_item(0, $urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(255));
        launch();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_jw_ack", 32'(jw_ack), 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_oob_err", 32'(oob_err), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_no_req", 32'(wr_req), 0);
        @(negedge clk); #1;
        chk("first_req", 32'(wr_req), 1);
        chk("first_addr", 32'(wr_addr), int'(wq[0][0].y) * W + int'(wq[0][0].x));
        wait_batch(500);

        add_item(5, 3, 2, 8'h2A);
        launch();
        wait_batch(100);
        chk("single_req_len", 32'(last_req_len), 1);
        add_item(4, 10, 1, 8'h11);
        add_item(7, 20, 0, 8'h22);
        launch();
        wait_batch(100);

        stall_left = 10;
        add_item(2, 100, 1, 8'h5C);
        launch();
        wait_batch(100);
        chk("stall_req_len", 32'(last_req_len), 11);

        add_item(7, 640, 0, 8'h33);
        launch();
        wait_batch(100);
        chk("oob_after", 32'(oob_err), 1);
        pulse_clear();
        chk("oob_cleared", 32'(oob_err), 0);

        ack_prob = 60;
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 16; w++) begin
                if ($urandom_range(1) == 1) begin
                    for (int j = 0; j < int'($urandom_range(3, 1)); j++) begin
                        add_item(w, $urandom_range(700), $urandom_range(4), $urandom_range(255));
                    end
                end
            end
            launch();
            wait_batch(1000);
        end

        ack_prob = 100;
        pulse_clear();
        for (int b = 0; b < FRAME / 128; b++) begin
            full_batch(8);
            wait_batch(2000);
        end
        chk("frame_done_set", 32'(frame_done), 1);
        full_batch(1);
        wait_batch(500);
        chk("frame_done_sticky", 32'(frame_done), 1);

        full_batch(8);
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 200 && !hit; c++) begin
                @(posedge clk); #3;
                if (wr_req === 1'b1 && wr_ack === 1'b1) begin
                    clear = 1'b1;
                    hit = 1;
                end
            end
            chk("clear_hit_write", 32'(hit), 1);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_frame_done", 32'(frame_done), 0);
        wait_batch(2000);
        for (int b = 0; b < FRAME / 128; b++) begin
            full_batch(8);
            wait_batch(2000);
        end
        chk("frame_done_again", 32'(frame_done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_arbiter.md
Name: result_arbiter

Overview:
- Collects finished pixel results from the 16 Julia workers and shares the single frame-buffer write port among them, using round-robin arbitration.
- Sits downstream of the workers, in parallel with dispatch, and handshakes each worker's result out so the worker can accept its next job.
- Converts the worker's (x, y) into a linear frame-buffer address and counts written pixels to flag frame completion.

Parameters:
NUM_WORKERS, 16, number of worker result channels (index width 4)
SCREEN_W, 640, pixels per row
SCREEN_H, 480, rows per frame
ITER_BITS, 8, width of iteration-count result
ADDR_BITS, 19, frame-buffer address width (must hold SCREEN_W*SCREEN_H-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
clear  input  1  one-cycle pulse: zero pixel count, frame_done, oob_err
jw_done  input  NUM_WORKERS  per-worker result-valid, held until acked
jw_x  input  NUM_WORKERS x 10 (packed [15:0][9:0])  result x coordinate
jw_y  input  NUM_WORKERS x 10 (packed [15:0][9:0])  result y coordinate
jw_iter  input  NUM_WORKERS x ITER_BITS  iteration count result
jw_ack  output  NUM_WORKERS  one-hot, one-cycle result-accepted pulse
wr_req  output  1  frame-buffer write request
wr_addr  output  ADDR_BITS  write address = y*SCREEN_W + x
wr_data  output  ITER_BITS  write data
wr_ack  input  1  frame-buffer accepted current write
frame_done  output  1  sticky: SCREEN_W*SCREEN_H pixels written since clear/reset
oob_err  output  1  sticky: a result with x>=SCREEN_W or y>=SCREEN_H was dropped

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. While rst is high at a rising edge: state=IDLE, rr_ptr=0, pix_cnt=0. All outputs go 0: jw_ack, wr_req, wr_addr, wr_data, frame_done, oob_err. Reset mid-write drops the transaction; no ack is issued.
- FSM states: IDLE, WRITE, ACK.
- IDLE, no jw_done bit set: stay in IDLE.
- IDLE, any jw_done bit set:
  - Select the first set index scanning from rr_ptr upward, wrapping 15->0.
  - Register it as grant_idx and latch wr_addr and wr_data from that channel.
  - Coordinates in range: go to WRITE.
  - Coordinates out of range: set oob_err and go to ACK; no write, pix_cnt unchanged.
- Latency: jw_done seen in cycle N gives wr_req=1 in cycle N+1.
- WRITE:
  - wr_req=1; wr_addr and wr_data held stable until wr_ack.
  - wr_ack=1 sampled: go to ACK, pix_cnt+=1.
  - wr_ack can arrive in the first WRITE cycle; the wait for it is unbounded.
- ACK:
  - jw_ack[grant_idx]=1 for exactly one cycle, wr_req=0.
  - rr_ptr <= (grant_idx+1) mod 16.
  - Next state is IDLE.
  - The worker drops jw_done in the cycle after it samples jw_ack, so IDLE never re-grants the same result.
- Throughput: at most one result per 3 cycles (wr_ack same cycle).
- Fairness:
  - Pointer advances past the last grantee, so a continuously requesting channel waits at most 15 grants.
  - All-16-requesting grants 0,1,...,15,0 after reset.
- Address arithmetic: unsigned, full ADDR_BITS product; max 479*640+639 = 307199.
- pix_cnt:
  - ADDR_BITS wide.
  - When the increment makes it equal SCREEN_W*SCREEN_H, set frame_done (sticky).
  - Further writes still occur; pix_cnt saturates at SCREEN_W*SCREEN_H.
- clear:
  - Acts in any state without disturbing the FSM or an in-flight write.
  - Coincident with an increment: clear wins (pix_cnt=0, frame_done=0).
  - Coincident with an oob detection: oob_err=0 (clear wins).
- jw_done changes on non-granted channels during WRITE/ACK are ignored until the next IDLE.

Test Plan:
1. Reset check: rst=1 for 2 cycles, all jw_done=1 -> jw_ack=0, wr_req=0, frame_done=0, oob_err=0; then rst=0 -> first grant is worker 0, wr_req high 1 cycle after IDLE sample.
2. Single result: jw_done[5]=1 with x=3, y=2, iter=0x2A, wr_ack tied 1 -> wr_addr=1283, wr_data=0x2A for 1 cycle. jw_ack=16'h0020 for 1 cycle. Next grant search starts at 6.
3. Round robin: jw_done=16'hFFFF held, each worker dropping done after its ack then reasserting -> grant order 0..15 then 0. No channel is granted twice before all others are granted once.
4. Stall: jw_done[2]=1, wr_ack=0 for 10 cycles then 1 -> wr_req high 11 cycles, addr/data constant, jw_ack[2] pulses once after wr_ack.
5. Out of range: jw_done[7]=1 with x=640, y=0 -> no wr_req, oob_err=1, jw_ack[7] pulses, pix_cnt unchanged. Then clear pulse -> oob_err=0.
6. Frame completion: feed 307200 in-range results (SCREEN_W=640, SCREEN_H=480) -> frame_done rises the cycle after the 307200th wr_ack. A clear coincident with a later write -> frame_done=0, pix_cnt=0.
